// File: rtl/mem_wait_if.sv
// Initiator/responder bundle for the wait-state memory port.
// Signal names follow the datapath's memory port (Req/We/Adr/WD/RD/Ready/Err/Busy).
interface mem_wait_if #(
  parameter int unsigned M = 32
);
  logic         Req;
  logic         We;
  logic [M-1:0] Adr;
  logic [M-1:0] WD;
  logic [M-1:0] RD;
  logic         Ready;
  logic         Err;
  logic         Busy;

  modport master (output Req, We, Adr, WD, input RD, Ready, Err, Busy);
  modport slave  (input Req, We, Adr, WD, output RD, Ready, Err, Busy);
endinterface

// File: rtl/mem_wait_responder.sv
// Word-addressed memory responder with a fixed number of wait states,
// flagging misaligned and out-of-range accesses.
module mem_wait_responder #(
  parameter int unsigned N    = 5,
  parameter int unsigned M    = 32,
  parameter int unsigned WAIT = 2
) (
  input  logic       CLK,
  input  logic       RST,
  mem_wait_if.slave  bus
);

  localparam int unsigned CW    = 4;
  localparam int unsigned DEPTH = 2 ** N;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            we_q;
  logic [M-1:0]    adr_q;
  logic [M-1:0]    wd_q;
  logic [M-1:0]    mem [DEPTH];

  logic            op_we_c;
  logic [M-1:0]    op_adr_c;
  logic [M-1:0]    op_wd_c;
  logic            op_err_c;
  logic [N-1:0]    idx_c;
  logic            enter_resp_c;
  logic            mem_we_c;
  logic [M-1:0]    resp_rd_c;

  // With zero wait states RESP is entered on the acceptance edge itself,
  // so the operation must come straight from the bus rather than the capture regs.
  always_comb begin
    op_we_c      = we_q;
    op_adr_c     = adr_q;
    op_wd_c      = wd_q;
    if (state == S_IDLE) begin
      op_we_c  = bus.We;
      op_adr_c = bus.Adr;
      op_wd_c  = bus.WD;
    end
    op_err_c     = (op_adr_c[1:0] != 2'b00) || (op_adr_c[M-1:N+2] != '0);
    idx_c        = op_adr_c[N+1:2];
    enter_resp_c = ((state == S_IDLE) && bus.Req && (WAIT == 0)) ||
                   ((state == S_WAIT) && (cnt == '0));
    mem_we_c     = RST && enter_resp_c && op_we_c && !op_err_c;
    resp_rd_c    = '0;
    if (!op_err_c && !op_we_c) resp_rd_c = mem[idx_c];
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge CLK) begin
    if (mem_we_c) mem[idx_c] <= op_wd_c;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= S_IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      wd_q      <= '0;
      bus.RD    <= '0;
      bus.Ready <= 1'b0;
      bus.Err   <= 1'b0;
      bus.Busy  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.Req) begin
            we_q     <= bus.We;
            adr_q    <= bus.Adr;
            wd_q     <= bus.WD;
            bus.Busy <= 1'b1;
            cnt      <= CW'(WAIT - 1);
            state    <= (WAIT == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == '0) state <= S_RESP;
          else           cnt   <= cnt - 1'b1;
        end
        S_RESP: begin
          state     <= S_IDLE;
          bus.Busy  <= 1'b0;
          bus.Ready <= 1'b0;
          bus.Err   <= 1'b0;
          bus.RD    <= '0;
        end
        default: state <= S_IDLE;
      endcase
      // Response is launched on the RESP-entry edge from either IDLE or WAIT.
      if (enter_resp_c) begin
        bus.Ready <= 1'b1;
        bus.Err   <= op_err_c;
        bus.RD    <= resp_rd_c;
      end
    end
  end

endmodule

// File: tb/tb_mem_wait_responder.sv
// Directed bench for mem_wait_responder: a WAIT=2 instance for the main
// sequence and a WAIT=0 instance for the zero-latency case.
module tb_mem_wait_responder;

  localparam int unsigned WAIT_A = 2;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  mem_wait_if #(.M(32)) bus_a ();
  mem_wait_if #(.M(32)) bus_b ();

  mem_wait_responder #(.N(5), .M(32), .WAIT(WAIT_A)) dut_a (.CLK(clk), .RST(rst), .bus(bus_a));
  mem_wait_responder #(.N(5), .M(32), .WAIT(0))      dut_b (.CLK(clk), .RST(rst), .bus(bus_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One complete access on instance A; optionally drops Req right after acceptance.
  task automatic access(input string tag, input logic we, input logic [31:0] adr,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_err, input bit drop_req);
    int lat;
    lat = 0;
    @(negedge clk);
    bus_a.Req = 1'b1; bus_a.We = we; bus_a.Adr = adr; bus_a.WD = wd;
    @(posedge clk);
    for (int n = 1; n <= int'(WAIT_A) + 4; n++) begin
      @(negedge clk);
      if (n == 1) begin
        check({tag, ":busy_e0"}, 32'(bus_a.Busy), 32'd1);
        if (drop_req) bus_a.Req = 1'b0;
      end
      if (bus_a.Ready) begin
        lat = n;
        break;
      end
    end
    check({tag, ":latency"}, 32'(lat), 32'(WAIT_A + 1));
    check({tag, ":rd"}, bus_a.RD, exp_rd);
    check({tag, ":err"}, 32'(bus_a.Err), 32'(exp_err));
    bus_a.Req = 1'b0;
    @(negedge clk);
    check({tag, ":ready_low"}, 32'(bus_a.Ready), 32'd0);
    check({tag, ":busy_low"}, 32'(bus_a.Busy), 32'd0);
  endtask

  initial begin
    int r1, r2, nready;
    logic seen;
    errors = 0;
    checks = 0;
    rst = 1'b0;
    bus_a.Req = 1'b0; bus_a.We = 1'b0; bus_a.Adr = '0; bus_a.WD = '0;
    bus_b.Req = 1'b0; bus_b.We = 1'b0; bus_b.Adr = '0; bus_b.WD = '0;
    repeat (3) @(negedge clk);
    check("rst:ready", 32'(bus_a.Ready), 32'd0);
    check("rst:busy", 32'(bus_a.Busy), 32'd0);
    check("rst:err", 32'(bus_a.Err), 32'd0);
    check("rst:rd", bus_a.RD, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Basic write, then known contents for later comparisons.
    access("wr08", 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
    access("wr04", 1'b1, 32'h0000_0004, 32'h4444_4444, 32'h0, 1'b0, 1'b0);
    access("wr0c", 1'b1, 32'h0000_000C, 32'h0000_0000, 32'h0, 1'b0, 1'b0);
    access("wr10", 1'b1, 32'h0000_0010, 32'h1010_1010, 32'h0, 1'b0, 1'b0);
    access("wr00", 1'b1, 32'h0000_0000, 32'h0000_1111, 32'h0, 1'b0, 1'b0);
    access("wr7c", 1'b1, 32'h0000_007C, 32'h7C7C_0001, 32'h0, 1'b0, 1'b0);

    access("rd08", 1'b0, 32'h0000_0008, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    access("rd0c", 1'b0, 32'h0000_000C, 32'h0, 32'h0000_0000, 1'b0, 1'b0);
    access("rd7c", 1'b0, 32'h0000_007C, 32'h0, 32'h7C7C_0001, 1'b0, 1'b0);

    // Error cases leave memory untouched.
    access("wr06_err", 1'b1, 32'h0000_0006, 32'h1234_5678, 32'h0, 1'b1, 1'b0);
    access("rd04", 1'b0, 32'h0000_0004, 32'h0, 32'h4444_4444, 1'b0, 1'b0);
    access("rd80_err", 1'b0, 32'h0000_0080, 32'h0, 32'h0, 1'b1, 1'b0);
    access("rdhi_err", 1'b0, 32'h8000_0000, 32'h0, 32'h0, 1'b1, 1'b0);

    // Back-to-back reads with Req held high throughout.
    r1 = 0; r2 = 0; nready = 0;
    @(negedge clk);
    bus_a.Req = 1'b1; bus_a.We = 1'b0; bus_a.Adr = 32'h0000_0000;
    @(posedge clk);
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (bus_a.Ready) begin
        nready++;
        if (nready == 1) begin
          r1 = n;
          check("b2b:rd0", bus_a.RD, 32'h0000_1111);
          bus_a.Adr = 32'h0000_0008;
        end else begin
          r2 = n;
          check("b2b:rd1", bus_a.RD, 32'hDEAD_BEEF);
          bus_a.Req = 1'b0;
        end
      end
    end
    bus_a.Req = 1'b0;
    check("b2b:count", 32'(nready), 32'd2);
    check("b2b:first", 32'(r1), 32'(WAIT_A + 1));
    check("b2b:spacing", 32'(r2 - r1), 32'(WAIT_A + 2));

    // Reset one cycle after acceptance aborts the pending write.
    @(negedge clk);
    bus_a.Req = 1'b1; bus_a.We = 1'b1; bus_a.Adr = 32'h0000_0010; bus_a.WD = 32'hAAAA_5555;
    @(posedge clk);
    @(negedge clk);
    bus_a.Req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      seen = seen | bus_a.Ready;
    end
    check("abort:busy", 32'(bus_a.Busy), 32'd0);
    rst = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      seen = seen | bus_a.Ready;
    end
    check("abort:no_ready", 32'(seen), 32'd0);
    access("rd10", 1'b0, 32'h0000_0010, 32'h0, 32'h1010_1010, 1'b0, 1'b0);

    // Dropping Req mid-transaction does not cancel the access.
    access("rddrop", 1'b0, 32'h0000_0008, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);

    // Zero-wait instance: write then read-after-write, Req held continuously.
    r1 = 0; r2 = 0; nready = 0;
    @(negedge clk);
    bus_b.Req = 1'b1; bus_b.We = 1'b1; bus_b.Adr = 32'h0000_0014; bus_b.WD = 32'h5A5A_5A5A;
    @(posedge clk);
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (bus_b.Ready) begin
        nready++;
        if (nready == 1) begin
          r1 = n;
          check("w0:wr_err", 32'(bus_b.Err), 32'd0);
          check("w0:wr_busy", 32'(bus_b.Busy), 32'd1);
          bus_b.We = 1'b0;
        end else begin
          r2 = n;
          check("w0:rd", bus_b.RD, 32'h5A5A_5A5A);
          bus_b.Req = 1'b0;
        end
      end
    end
    bus_b.Req = 1'b0;
    check("w0:count", 32'(nready), 32'd2);
    check("w0:first", 32'(r1), 32'd1);
    check("w0:spacing", 32'(r2 - r1), 32'd2);
    @(negedge clk);
    check("w0:busy_low", 32'(bus_b.Busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
